switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   W-channel synchroniser and debouncer for mechanical switches and buttons.
//   Sits directly upstream of the GPI slot core: raw_in comes from board pins,
//   and db_out drives the GPI core's data_in.
//   Each channel has its own 2-FF synchroniser, stability counter and 4-state FSM.
//   One-cycle rise/fall ticks are provided for edge-driven consumers.
// PARAMETERS
//   W              8          number of independent input channels
//   STABLE_CYCLES  500000     consecutive clk cycles a new level must hold (>=1; 5 ms @ 100 MHz)
//   CNT_W          $clog2(STABLE_CYCLES), min 1   width of per-channel counter (localparam)
// PORTS
//   clk        in   1   system clock, rising-edge
//   reset      in   1   asynchronous, active-low reset
//   raw_in     in   W   raw, asynchronous switch/button levels
//   db_out     out  W   debounced levels (to GPI data_in)
//   rise_tick  out  W   1-cycle pulse when db_out[i] goes 0->1
//   fall_tick  out  W   1-cycle pulse when db_out[i] goes 1->0
// BEHAVIOUR
// - Reset (reset=0, async):
//   - All sync FFs, counters, db_out, rise_tick and fall_tick are cleared to 0.
//   - Every FSM goes to ST0.
//   - Takes effect immediately, including mid-count.
// - Sync: sync_in[i] = raw_in[i] delayed by 2 FFs. The FSM sees only sync_in.
// - FSM per channel; states ST0, W1, ST1, W0:
//   - ST0: sync_in=1 -> W1, cnt<=0; else stay. db_out=0.
//   - W1:  sync_in=0 -> ST0, cnt<=0 (glitch rejected, no tick).
//          sync_in=1 and cnt==STABLE_CYCLES-1 -> ST1; db_out<=1, rise_tick<=1.
//          else cnt<=cnt+1.
//   - ST1: sync_in=0 -> W0, cnt<=0; else stay. db_out=1.
//   - W0:  mirror of W1 (-> ST1 on glitch; -> ST0 with db_out<=0, fall_tick<=1).
// - Registered outputs:
//   - db_out, rise_tick and fall_tick are flops.
//   - Ticks are high for exactly one cycle, on the same edge db_out changes.
//   - Ticks are never both high on one channel.
// - Latency: with the new level held, db_out changes on the (STABLE_CYCLES+2)th rising edge
//   after the edge that first samples it (edge 0). STABLE_CYCLES=4 gives edge 6.
// - Rejection: any return to the old level before the count completes restarts the wait
//   from 0 on the next transition. Pulses narrower than STABLE_CYCLES never reach db_out.
// - Counter: never exceeds STABLE_CYCLES-1 and never wraps. It is cleared on every
//   entry to W0/W1.
// - Channels are fully independent. Simultaneous changes on several channels resolve
//   on the same edge.
// - After reset release with raw_in[i]=1: channel i debounces normally to 1 and emits
//   rise_tick.
// TESTING  (W=8, STABLE_CYCLES=4)
// - Reset low with raw_in=8'hFF -> db_out=8'h00, ticks=0 during reset.
//   Release -> db_out=8'hFF at edge 6 with rise_tick=8'hFF for 1 cycle.
// - raw_in[0] 0->1 held -> db_out[0]=1 exactly at edge 6; rise_tick[0]=1 for one cycle;
//   other bits unchanged.
// - raw_in[1] high 3 cycles then low -> db_out[1] stays 0; rise_tick and fall_tick
//   stay 0 throughout.
// - raw_in[2] toggles 1,0,1,0,1 on successive cycles, then held 1 -> db_out[2] rises
//   6 edges after the final 0->1; exactly one rise_tick.
// - raw_in 8'h00->8'hA5 held -> db_out=8'hA5 and rise_tick=8'hA5 on the same edge.
//   Then ->8'h00 -> fall_tick=8'hA5 and db_out=8'h00.
// - Assert reset while channel 3 is in W1 with cnt=2 -> db_out[3]=0 immediately.
//   Release with raw_in[3]=1 -> full 6-edge wait again.

Source files
------------

// File: rtl/switch_debouncer.sv
// W-channel switch synchroniser and debouncer: each channel has a 2-FF synchroniser,
// a stability counter and a 4-state FSM driving a registered level plus rise/fall ticks.
module switch_debouncer #(
    parameter int unsigned W             = 8,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] db_out,
    output logic [W-1:0] rise_tick,
    output logic [W-1:0] fall_tick
);

    localparam int unsigned      CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST0,
        W1,
        ST1,
        W0
    } state_t;

    logic [W-1:0] sync_a;
    logic [W-1:0] sync_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a  <= '0;
            sync_in <= '0;
        end else begin
            sync_a  <= raw_in;
            sync_in <= sync_a;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST0;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // A wait state falls back to its stable state on any return to the old level.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                ST0: begin
                    if (sync_in[i]) begin
                        state_d = W1;
                        cnt_d   = '0;
                    end
                end
                W1: begin
                    if (!sync_in[i]) begin
                        state_d = ST0;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST1;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST1: begin
                    if (!sync_in[i]) begin
                        state_d = W0;
                        cnt_d   = '0;
                    end
                end
                W0: begin
                    if (sync_in[i]) begin
                        state_d = ST1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST0;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST0;
                    cnt_d   = '0;
                end
            endcase
        end

        assign db_out[i]    = db_q;
        assign rise_tick[i] = rise_q;
        assign fall_tick[i] = fall_q;
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: a run-length reference model queues the expected
// outputs each edge and a monitor compares them against the DUT just after the edge.
module tb_switch_debouncer;

    localparam int unsigned W      = 8;
    localparam int unsigned STABLE = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_tick;
    logic [W-1:0] fall_tick;

    int unsigned checks;
    int unsigned errors;

    logic [3*W-1:0] expq[$];

    switch_debouncer #(
        .W            (W),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in),
        .db_out   (db_out),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: a channel flips once the synchronised input has disagreed with the
    // debounced level on STABLE+1 consecutive edges (one edge to leave the stable state,
    // then STABLE counted edges).
    initial begin
        logic [W-1:0] s1, s2, mdb, er, ef;
        int unsigned  run[W];
        s1 = '0; s2 = '0; mdb = '0;
        for (int c = 0; c < W; c++) run[c] = 0;
        forever begin
            @(posedge clk);
            er = '0;
            ef = '0;
            if (!reset) begin
                s1 = '0; s2 = '0; mdb = '0;
                for (int c = 0; c < W; c++) run[c] = 0;
            end else begin
                for (int c = 0; c < W; c++) begin
                    if (s2[c] != mdb[c]) run[c] = run[c] + 1;
                    else run[c] = 0;
                    if (run[c] == STABLE + 1) begin
                        mdb[c] = ~mdb[c];
                        if (mdb[c]) er[c] = 1'b1;
                        else ef[c] = 1'b1;
                        run[c] = 0;
                    end
                end
                s2 = s1;
                s1 = raw_in;
            end
            expq.push_back({mdb, er, ef});
        end
    end

    // Monitor: every edge the DUT presents a fresh output word.
    initial begin
        logic [3*W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t actual=0 required=1", $time);
            end else begin
                e = expq.pop_front();
                chk("db_out", db_out, e[3*W-1:2*W]);
                chk("rise_tick", rise_tick, e[2*W-1:W]);
                chk("fall_tick", fall_tick, e[W-1:0]);
                chk("ticks_exclusive", rise_tick & fall_tick, '0);
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] toggles;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        raw_in = '0;
        #1;
        reset  = 1'b0;
        raw_in = 8'hFF;
        cycles(3);
        chk("reset_db_out", db_out, '0);
        chk("reset_rise", rise_tick, '0);
        chk("reset_fall", fall_tick, '0);
        reset = 1'b1;
        cycles(10);

        raw_in = 8'h00; cycles(10);
        raw_in = 8'h01; cycles(10);
        raw_in = 8'h00; cycles(10);

        raw_in = 8'h02; cycles(3);
        raw_in = 8'h00; cycles(10);

        toggles = 8'b0001_0101;
        for (int k = 0; k < 5; k++) begin
            raw_in = {5'b0, toggles[k], 2'b00};
            cycles(1);
        end
        cycles(10);
        raw_in = 8'h00; cycles(10);

        raw_in = 8'hA5; cycles(10);
        raw_in = 8'h00; cycles(10);

        raw_in = 8'h07; cycles(10);
        raw_in = 8'h0F; cycles(5);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_db_out", db_out, '0);
        chk("async_reset_rise", rise_tick, '0);
        chk("async_reset_fall", fall_tick, '0);
        cycles(1);
        reset = 1'b1;
        cycles(10);

        for (int k = 0; k < 60; k++) begin
            raw_in = W'($urandom);
            cycles($urandom_range(1, 8));
        end
        for (int k = 0; k < 200; k++) begin
            raw_in = raw_in ^ (W'($urandom) & W'($urandom));
            cycles(1);
        end
        raw_in = '0;
        cycles(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
